// File: rtl/jt7759_seq.sv
// jt7759_seq: uPD7759 phrase sequencer. Reads the ROM header, looks up the phrase pointer and streams bytes to the ADPCM decoder.
// Optional header signature check is compiled in when JT7759_SIGCHK_EN is defined.

module jt7759_seq #(
  parameter int          TBL_BASE = 5,
  parameter logic [31:0] SIG      = 32'h5AA56955
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen_ctl,
  input  logic        stn,
  input  logic [7:0]  phrase,
  output logic        busyn,
  output logic        err,
  output logic        ctrl_flush,
  output logic [16:0] ctrl_addr,
  output logic        ctrl_busyn,
  output logic        ctrl_cs,
  input  logic [7:0]  ctrl_din,
  input  logic        ctrl_ok,
  input  logic        dec_req,
  output logic [7:0]  dec_data,
  output logic        dec_ok,
  input  logic        dec_end
);

  typedef enum logic [2:0] {IDLE, CNT, SIGN, PTR, SEEK, PLAY} state_t;

  state_t      state, state_nx;
  logic        stn_l;
  logic [7:0]  phr, phr_nx, hi, hi_nx, lo, lo_nx, ddata_nx;
  logic [2:0]  idx, idx_nx;
  logic        sig_bad, sig_bad_nx;
  logic        busyn_nx, err_nx, flush_nx, cbusyn_nx, cs_nx, dok_nx;
  logic [16:0] addr_nx, tbl_addr;
  logic        got, req_ok;

  assign got      = ctrl_cs & ctrl_ok;
  // A new request never overlaps a flush and always follows a low cycle of ctrl_cs
  assign req_ok   = ~ctrl_cs & ~ctrl_flush;
  assign tbl_addr = 17'(TBL_BASE) + {8'd0, phr, 1'b0} - 17'd1;

`ifdef JT7759_SIGCHK_EN
  logic [31:0] sig_sh;
  logic [7:0]  sig_byte;
  assign sig_sh   = SIG << {idx[1:0], 3'b000};
  assign sig_byte = sig_sh[31:24];
`else
  logic unused_sig;
  assign unused_sig = ^SIG;
`endif

  always_comb begin
    state_nx   = state;
    phr_nx     = phr;
    idx_nx     = idx;
    hi_nx      = hi;
    lo_nx      = lo;
    sig_bad_nx = sig_bad;
    busyn_nx   = busyn;
    err_nx     = err;
    flush_nx   = 1'b0;
    addr_nx    = ctrl_addr;
    cbusyn_nx  = ctrl_busyn;
    cs_nx      = ctrl_cs;
    ddata_nx   = dec_data;
    dok_nx     = 1'b0;
    if (cen_ctl) begin
      err_nx = 1'b0;
      case (state)
        IDLE: if (stn_l && !stn) begin
          phr_nx    = phrase;
          busyn_nx  = 1'b0;
          cbusyn_nx = 1'b0;
          flush_nx  = 1'b1;
          addr_nx   = 17'h1FFFF;
          idx_nx    = 3'd0;
          state_nx  = CNT;
        end
        CNT: if (got) begin
          cs_nx = 1'b0;
          if (phr > ctrl_din) begin
            err_nx    = 1'b1;
            busyn_nx  = 1'b1;
            cbusyn_nx = 1'b1;
            state_nx  = IDLE;
          end else begin
`ifdef JT7759_SIGCHK_EN
            idx_nx     = 3'd0;
            sig_bad_nx = 1'b0;
            state_nx   = SIGN;
`else
            flush_nx = 1'b1;
            addr_nx  = tbl_addr;
            idx_nx   = 3'd0;
            state_nx = PTR;
`endif
          end
        end else if (req_ok) cs_nx = 1'b1;
`ifdef JT7759_SIGCHK_EN
        SIGN: if (got) begin
          cs_nx      = 1'b0;
          sig_bad_nx = sig_bad | (ctrl_din != sig_byte);
          if (idx == 3'd3) begin
            if (sig_bad_nx) begin
              err_nx    = 1'b1;
              busyn_nx  = 1'b1;
              cbusyn_nx = 1'b1;
              state_nx  = IDLE;
            end else begin
              flush_nx = 1'b1;
              addr_nx  = tbl_addr;
              idx_nx   = 3'd0;
              state_nx = PTR;
            end
          end else idx_nx = idx + 3'd1;
        end else if (req_ok) cs_nx = 1'b1;
`endif
        PTR: if (got) begin
          cs_nx = 1'b0;
          if (idx == 3'd0) begin
            hi_nx  = ctrl_din;
            idx_nx = 3'd1;
          end else begin
            lo_nx    = ctrl_din;
            state_nx = SEEK;
          end
        end else if (req_ok) cs_nx = 1'b1;
        SEEK: begin
          // Table holds word pointers; hi[7] becomes address bit 16
          flush_nx = 1'b1;
          addr_nx  = {hi, lo, 1'b0} - 17'd1;
          state_nx = PLAY;
        end
        PLAY: if (dec_end) begin
          cs_nx     = 1'b0;
          busyn_nx  = 1'b1;
          cbusyn_nx = 1'b1;
          state_nx  = IDLE;
        end else if (got) begin
          cs_nx    = 1'b0;
          ddata_nx = ctrl_din;
          dok_nx   = 1'b1;
        end else if (dec_req && req_ok && !dec_ok) cs_nx = 1'b1;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      stn_l      <= 1'b1;
      phr        <= 8'd0;
      idx        <= 3'd0;
      hi         <= 8'd0;
      lo         <= 8'd0;
      sig_bad    <= 1'b0;
      busyn      <= 1'b1;
      err        <= 1'b0;
      ctrl_flush <= 1'b0;
      ctrl_addr  <= 17'd0;
      ctrl_busyn <= 1'b1;
      ctrl_cs    <= 1'b0;
      dec_data   <= 8'd0;
      dec_ok     <= 1'b0;
    end else begin
      if (cen_ctl) stn_l <= stn;
      state      <= state_nx;
      phr        <= phr_nx;
      idx        <= idx_nx;
      hi         <= hi_nx;
      lo         <= lo_nx;
      sig_bad    <= sig_bad_nx;
      busyn      <= busyn_nx;
      err        <= err_nx;
      ctrl_flush <= flush_nx;
      ctrl_addr  <= addr_nx;
      ctrl_busyn <= cbusyn_nx;
      ctrl_cs    <= cs_nx;
      dec_data   <= ddata_nx;
      dec_ok     <= dok_nx;
    end
  end

endmodule

// File: tb/tb_jt7759_seq.sv
// Bench for jt7759_seq: ROM/fetch-block and decoder models, expected flushes and bytes queued per phrase.
module tb_jt7759_seq;
  logic        clk = 1'b0, rst = 1'b1, cen_ctl = 1'b1, stn = 1'b1;
  logic [7:0]  phrase = 8'd0;
  logic        busyn, err, ctrl_flush, ctrl_busyn, ctrl_cs, dec_ok;
  logic [16:0] ctrl_addr;
  logic [7:0]  dec_data;
  logic [7:0]  ctrl_din = 8'd0;
  logic        ctrl_ok = 1'b0, dec_req = 1'b0, dec_end = 1'b0;

  jt7759_seq dut (
    .clk(clk), .rst(rst), .cen_ctl(cen_ctl), .stn(stn), .phrase(phrase),
    .busyn(busyn), .err(err), .ctrl_flush(ctrl_flush), .ctrl_addr(ctrl_addr),
    .ctrl_busyn(ctrl_busyn), .ctrl_cs(ctrl_cs), .ctrl_din(ctrl_din), .ctrl_ok(ctrl_ok),
    .dec_req(dec_req), .dec_data(dec_data), .dec_ok(dec_ok), .dec_end(dec_end)
  );

  always #5 clk = ~clk;

  logic [7:0]  rom [0:131071];
  logic [16:0] act_flush[$], exp_flush[$];
  logic [7:0]  act_dec[$], exp_dec[$];
  int          checks = 0, failures = 0;
  int          err_cycles = 0, ovl_cnt = 0, received = 0, dly = 0;
  int          dec_go = 0, dec_go_seen = 0, dec_n = 0;
  logic        dec_mode = 1'b0, served = 1'b0, dec_active = 1'b0;
  logic [16:0] faddr = 17'd0;

  // Fetch block and decoder models, plus output recorder
  always @(negedge clk) begin
    if (rst) begin
      ctrl_ok = 1'b0; served = 1'b0; dec_end = 1'b0; dec_active = 1'b0; dec_req = 1'b0;
      dec_go_seen = dec_go;
    end else begin
      if (ctrl_flush) begin
        act_flush.push_back(ctrl_addr);
        faddr = ctrl_addr;
        if (ctrl_cs) ovl_cnt++;
      end
      if (dec_ok) begin act_dec.push_back(dec_data); received++; end
      if (err) err_cycles++;
      if (!ctrl_cs) begin ctrl_ok = 1'b0; served = 1'b0; end
      else if (ctrl_ok) ctrl_ok = 1'b0;
      else if (!served) begin
        if (dly == 0) begin
          faddr = faddr + 17'd1;
          ctrl_din = rom[faddr];
          ctrl_ok = 1'b1;
          served = 1'b1;
          dly = $urandom_range(0, 2);
        end else dly--;
      end
      if (dec_go != dec_go_seen) begin
        dec_go_seen = dec_go; dec_active = 1'b1; received = 0; dec_end = 1'b0;
      end else if (dec_end) begin
        dec_end = 1'b0; dec_active = 1'b0;
      end else if (dec_active && received >= dec_n && (!dec_mode || ctrl_ok)) dec_end = 1'b1;
      dec_req = dec_active && !dec_end;
    end
  end

  task automatic build_exp(input logic [7:0] p, input int n, output logic expect_err);
    logic [16:0] start;
    exp_flush.delete(); exp_dec.delete();
    expect_err = 1'b0;
    exp_flush.push_back(17'h1FFFF);
    if (p > rom[0]) begin expect_err = 1'b1; return; end
`ifdef JT7759_SIGCHK_EN
    if ({rom[1], rom[2], rom[3], rom[4]} != 32'h5AA56955) begin expect_err = 1'b1; return; end
`endif
    exp_flush.push_back(17'd5 + 17'(2 * p) - 17'd1);
    start = {rom[17'd5 + 17'(2 * p)], rom[17'd6 + 17'(2 * p)], 1'b0};
    exp_flush.push_back(start - 17'd1);
    for (int i = 0; i < n; i++) exp_dec.push_back(rom[start + 17'(i)]);
  endtask

  task automatic start_phrase(input logic [7:0] p, input int n, input logic mode);
    phrase = p; dec_n = n; dec_mode = mode; dec_go++;
    @(posedge clk); #1 stn = 1'b0;
    repeat (2) @(posedge clk);
    #1 stn = 1'b1;
  endtask

  task automatic wait_done(output logic timeout);
    timeout = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (busyn) begin timeout = 1'b0; break; end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_bytes(input int k, output logic timeout);
    timeout = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (received >= k) begin timeout = 1'b0; break; end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busyn !== 1'b1) begin failures++; $display("FAIL reset_busyn got=%b exp=1", busyn); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (ctrl_flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", ctrl_flush); end
    checks++; if (ctrl_addr !== 17'd0) begin failures++; $display("FAIL reset_addr got=%h exp=0", ctrl_addr); end
    checks++; if (ctrl_busyn !== 1'b1) begin failures++; $display("FAIL reset_ctrl_busyn got=%b exp=1", ctrl_busyn); end
    checks++; if (ctrl_cs !== 1'b0) begin failures++; $display("FAIL reset_cs got=%b exp=0", ctrl_cs); end
    checks++; if (dec_data !== 8'd0) begin failures++; $display("FAIL reset_dec_data got=%h exp=0", dec_data); end
    checks++; if (dec_ok !== 1'b0) begin failures++; $display("FAIL reset_dec_ok got=%b exp=0", dec_ok); end
  endtask

  task automatic test_play;
    logic [7:0] plist [3];
    int nlist [3];
    int bf, bd, be;
    logic ee, to;
    plist = '{8'd2, 8'd3, 8'd0};
    nlist = '{6, 4, 5};
    for (int t = 0; t < 3; t++) begin
      bf = act_flush.size(); bd = act_dec.size(); be = err_cycles;
      build_exp(plist[t], nlist[t], ee);
      start_phrase(plist[t], nlist[t], 1'b0);
      checks++; if (busyn !== 1'b0 || ctrl_busyn !== 1'b0) begin failures++; $display("FAIL play_busy p=%0d got busyn=%b ctrl_busyn=%b exp=0", plist[t], busyn, ctrl_busyn); end
      wait_done(to);
      checks++; if (to) begin failures++; $display("FAIL play_timeout p=%0d busyn stayed low", plist[t]); end
      checks++; if (ctrl_busyn !== 1'b1) begin failures++; $display("FAIL play_ctrl_busyn p=%0d got=%b exp=1", plist[t], ctrl_busyn); end
      checks++;
      if (act_flush.size() - bf != exp_flush.size()) begin failures++; $display("FAIL play_flush_count p=%0d got=%0d exp=%0d", plist[t], act_flush.size() - bf, exp_flush.size()); end
      else foreach (exp_flush[k]) begin
        checks++; if (act_flush[bf + k] !== exp_flush[k]) begin failures++; $display("FAIL play_flush p=%0d #%0d got=%h exp=%h", plist[t], k, act_flush[bf + k], exp_flush[k]); end
      end
      checks++;
      if (act_dec.size() - bd != exp_dec.size()) begin failures++; $display("FAIL play_dec_count p=%0d got=%0d exp=%0d", plist[t], act_dec.size() - bd, exp_dec.size()); end
      else foreach (exp_dec[k]) begin
        checks++; if (act_dec[bd + k] !== exp_dec[k]) begin failures++; $display("FAIL play_dec p=%0d #%0d got=%h exp=%h", plist[t], k, act_dec[bd + k], exp_dec[k]); end
      end
      checks++; if (err_cycles - be != 0) begin failures++; $display("FAIL play_err p=%0d got=%0d exp=0", plist[t], err_cycles - be); end
    end
  endtask

  task automatic test_err_range;
    int bf, bd, be;
    logic ee, to;
    bf = act_flush.size(); bd = act_dec.size(); be = err_cycles;
    build_exp(8'd4, 4, ee);
    start_phrase(8'd4, 4, 1'b0);
    wait_done(to);
    checks++; if (to) begin failures++; $display("FAIL range_timeout busyn stayed low"); end
    checks++; if (err_cycles - be != 1) begin failures++; $display("FAIL range_err_pulses got=%0d exp=1", err_cycles - be); end
    checks++; if (act_flush.size() - bf != 1) begin failures++; $display("FAIL range_flush_count got=%0d exp=1", act_flush.size() - bf); end
    else begin
      checks++; if (act_flush[bf] !== 17'h1FFFF) begin failures++; $display("FAIL range_flush got=%h exp=1ffff", act_flush[bf]); end
    end
    checks++; if (act_dec.size() - bd != 0) begin failures++; $display("FAIL range_dec_count got=%0d exp=0", act_dec.size() - bd); end
  endtask

  task automatic test_sig;
    int bf, bd, be;
    logic ee, to;
    rom[1] = 8'h00;
    bf = act_flush.size(); bd = act_dec.size(); be = err_cycles;
    build_exp(8'd2, 4, ee);
    start_phrase(8'd2, 4, 1'b0);
    wait_done(to);
    checks++; if (to) begin failures++; $display("FAIL sig_timeout busyn stayed low"); end
    checks++; if (err_cycles - be != (ee ? 1 : 0)) begin failures++; $display("FAIL sig_err_pulses got=%0d exp=%0d", err_cycles - be, ee ? 1 : 0); end
    checks++; if (act_flush.size() - bf != exp_flush.size()) begin failures++; $display("FAIL sig_flush_count got=%0d exp=%0d", act_flush.size() - bf, exp_flush.size()); end
    checks++;
    if (act_dec.size() - bd != exp_dec.size()) begin failures++; $display("FAIL sig_dec_count got=%0d exp=%0d", act_dec.size() - bd, exp_dec.size()); end
    else foreach (exp_dec[k]) begin
      checks++; if (act_dec[bd + k] !== exp_dec[k]) begin failures++; $display("FAIL sig_dec #%0d got=%h exp=%h", k, act_dec[bd + k], exp_dec[k]); end
    end
    rom[1] = 8'h5A;
  endtask

  task automatic test_stn_ignored;
    int bf, bd;
    logic ee, to;
    bf = act_flush.size(); bd = act_dec.size();
    build_exp(8'd2, 10, ee);
    start_phrase(8'd2, 10, 1'b0);
    wait_bytes(3, to);
    checks++; if (to) begin failures++; $display("FAIL ignore_bytes_timeout got=%0d exp>=3", received); end
    phrase = 8'd3;
    #1 stn = 1'b0;
    repeat (2) @(posedge clk);
    #1 stn = 1'b1;
    wait_done(to);
    checks++; if (to) begin failures++; $display("FAIL ignore_timeout busyn stayed low"); end
    checks++; if (act_flush.size() - bf != 3) begin failures++; $display("FAIL ignore_flush_count got=%0d exp=3", act_flush.size() - bf); end
    checks++;
    if (act_dec.size() - bd != exp_dec.size()) begin failures++; $display("FAIL ignore_dec_count got=%0d exp=%0d", act_dec.size() - bd, exp_dec.size()); end
    else foreach (exp_dec[k]) begin
      checks++; if (act_dec[bd + k] !== exp_dec[k]) begin failures++; $display("FAIL ignore_dec #%0d got=%h exp=%h", k, act_dec[bd + k], exp_dec[k]); end
    end
  endtask

  task automatic test_end_with_ok;
    int bd;
    logic ee, to;
    bd = act_dec.size();
    build_exp(8'd1, 3, ee);
    start_phrase(8'd1, 3, 1'b1);
    wait_done(to);
    checks++; if (to) begin failures++; $display("FAIL endok_timeout busyn stayed low"); end
    checks++;
    if (act_dec.size() - bd != 3) begin failures++; $display("FAIL endok_dec_count got=%0d exp=3", act_dec.size() - bd); end
    else foreach (exp_dec[k]) begin
      checks++; if (act_dec[bd + k] !== exp_dec[k]) begin failures++; $display("FAIL endok_dec #%0d got=%h exp=%h", k, act_dec[bd + k], exp_dec[k]); end
    end
    checks++; if (ctrl_cs !== 1'b0 || ctrl_busyn !== 1'b1) begin failures++; $display("FAIL endok_idle got cs=%b ctrl_busyn=%b exp cs=0 ctrl_busyn=1", ctrl_cs, ctrl_busyn); end
  endtask

  task automatic test_rst_mid;
    int bf, bd;
    logic ee, to;
    build_exp(8'd2, 40, ee);
    start_phrase(8'd2, 40, 1'b0);
    wait_bytes(3, to);
    checks++; if (to) begin failures++; $display("FAIL rstmid_bytes_timeout got=%0d exp>=3", received); end
    @(posedge clk); #2 rst = 1'b1;
    #1;
    checks++; if (busyn !== 1'b1 || ctrl_busyn !== 1'b1) begin failures++; $display("FAIL rstmid_busy got busyn=%b ctrl_busyn=%b exp=1", busyn, ctrl_busyn); end
    checks++; if (ctrl_cs !== 1'b0 || ctrl_flush !== 1'b0 || err !== 1'b0 || dec_ok !== 1'b0) begin failures++; $display("FAIL rstmid_ctl got cs=%b flush=%b err=%b dec_ok=%b exp=0", ctrl_cs, ctrl_flush, err, dec_ok); end
    checks++; if (ctrl_addr !== 17'd0 || dec_data !== 8'd0) begin failures++; $display("FAIL rstmid_data got addr=%h dec_data=%h exp=0", ctrl_addr, dec_data); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    bf = act_flush.size(); bd = act_dec.size();
    build_exp(8'd2, 5, ee);
    start_phrase(8'd2, 5, 1'b0);
    wait_done(to);
    checks++; if (to) begin failures++; $display("FAIL rstmid_restart_timeout busyn stayed low"); end
    checks++; if (act_flush.size() - bf != 3) begin failures++; $display("FAIL rstmid_flush_count got=%0d exp=3", act_flush.size() - bf); end
    else begin
      checks++; if (act_flush[bf + 2] !== exp_flush[2]) begin failures++; $display("FAIL rstmid_seek got=%h exp=%h", act_flush[bf + 2], exp_flush[2]); end
    end
    checks++;
    if (act_dec.size() - bd != exp_dec.size()) begin failures++; $display("FAIL rstmid_dec_count got=%0d exp=%0d", act_dec.size() - bd, exp_dec.size()); end
    else foreach (exp_dec[k]) begin
      checks++; if (act_dec[bd + k] !== exp_dec[k]) begin failures++; $display("FAIL rstmid_dec #%0d got=%h exp=%h", k, act_dec[bd + k], exp_dec[k]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 131072; i++) rom[i] = 8'((i * 37 + 11) ^ (i >> 9));
    rom[0] = 8'd3;
    rom[1] = 8'h5A; rom[2] = 8'hA5; rom[3] = 8'h69; rom[4] = 8'h55;
    rom[5] = 8'h00; rom[6] = 8'h30;
    rom[7] = 8'h00; rom[8] = 8'h40;
    rom[9] = 8'h00; rom[10] = 8'h10;
    rom[11] = 8'h80; rom[12] = 8'h00;
    test_reset;
    test_play;
    test_err_range;
    test_sig;
    test_stn_ignored;
    test_end_with_ok;
    test_rst_mid;
    checks++; if (ovl_cnt != 0) begin failures++; $display("FAIL flush_cs_overlap got=%0d exp=0", ovl_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
